fc1_act_serializer: RTL
=======================

FC1_ACT_SERIALIZER -- requirements
Module: fc1_act_serializer

Interface
REQ-001 SHALL have parameter CO, default 3, meaning lanes per upstream accumulator beat.
REQ-002 SHALL have parameter ACC_BW, default 24, meaning signed width of each accumulator lane.
REQ-003 SHALL have parameter B_BW, default 16, meaning signed bias width.
REQ-004 SHALL have parameter OUT_BW, default 8, meaning unsigned activation width.
REQ-005 SHALL have parameter SHIFT, default 7, meaning arithmetic right-shift for requantisation.
REQ-006 SHALL have parameter NGROUP, default 16, meaning beats per inference (CO*NGROUP neurons).
REQ-007 clk  input  1  clock, rising-edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 i_in_valid  input  1  single-cycle strobe, accumulator beat present.
REQ-010 i_in_acc  input  CO*ACC_BW  packed signed sums, lane k at [k*ACC_BW +: ACC_BW].
REQ-011 o_ot_valid  output  1  activation present on o_ot_data.
REQ-012 i_ot_ready  input  1  downstream accepts activation.
REQ-013 o_ot_data  output  OUT_BW  quantised activation.
REQ-014 o_ot_idx  output  clog2(CO*NGROUP)  neuron index of o_ot_data.
REQ-015 o_ot_last  output  1  high with final neuron of inference.
REQ-016 o_busy  output  1  high whenever state is not IDLE.
REQ-017 o_overrun  output  1  sticky, beat dropped while busy.

Function
REQ-018 States SHALL be IDLE, CALC, SEND; IDLE->CALC on i_in_valid; CALC->SEND after exactly one cycle; SEND->IDLE on handshake of lane CO-1.
REQ-019 In IDLE, i_in_valid SHALL capture all CO lanes of i_in_acc into an input register.
REQ-020 In CALC, each lane SHALL compute s = acc + sign-extended bias[group*CO+k] at ACC_BW+1 bits, with bias from a ROM loaded from fc1_bias.mem.
REQ-021 ReLU: s<0 SHALL yield 0; otherwise q = s >>> SHIFT, saturated to 2^OUT_BW-1.
REQ-022 CALC SHALL register all CO results into an output buffer; lane counter reset to 0.
REQ-023 In SEND, o_ot_valid SHALL be 1, o_ot_data = buffer[lane], o_ot_idx = group*CO+lane.
REQ-024 Handshake = o_ot_valid & i_ot_ready; on handshake lane increments; o_ot_data/idx SHALL stay stable while valid & !ready.
REQ-025 Handshake of lane CO-1 SHALL increment group, wrapping NGROUP-1 -> 0.
REQ-026 o_ot_last SHALL equal (group==NGROUP-1)&&(lane==CO-1)&&o_ot_valid.
REQ-027 Latency: i_in_valid at cycle t SHALL give first o_ot_valid at t+2; with ready tied high, lanes at t+2..t+CO+1, IDLE at t+CO+2.
REQ-028 i_in_valid in CALC or SEND SHALL be dropped and set o_overrun to 1; only reset clears it.
REQ-029 i_in_valid coincident with final handshake SHALL be dropped (state still SEND) and set o_overrun.
REQ-030 o_busy SHALL be 0 only in IDLE.

Reset
REQ-031 reset_n low SHALL force IDLE, group=0, lane=0, buffers=0, o_ot_valid=0, o_ot_data=0, o_ot_idx=0, o_ot_last=0, o_busy=0, o_overrun=0.
REQ-032 Reset mid-SEND SHALL discard buffered activations; first beat after release is group 0.

Structure
REQ-033 CO, ACC_BW, B_BW, OUT_BW, SHIFT, NGROUP SHALL live in the shared defines header used by the CNN core.
REQ-034 Per-lane bias/ReLU/quantise SHALL be one sub-module, fc_relu_quant, instantiated CO times via generate.
REQ-035 State encoding and counters SHALL stay local to fc1_act_serializer.

Verification
REQ-036 Beat acc={100,-50,40000}, bias 0, ready high -> outputs 0,0,255 at t+2..t+4, idx 0,1,2.
REQ-037 acc=1000, bias=-872 lane0 -> s=128, output 1; acc=127, bias 0 -> output 0.
REQ-038 Ready low 3 cycles on lane1 -> data/idx held stable, lane2 follows only after ready.
REQ-039 Beat during SEND -> dropped, o_overrun=1 until reset, output sequence unchanged.
REQ-040 16 beats spaced 6 cycles -> idx 0..47 in order, o_ot_last only on idx 47, group wraps to 0.
REQ-041 reset_n low during SEND lane1 -> all outputs 0 at once; next beat emitted as idx 0..2.

Source files
------------

// File: rtl/fc1_act_serializer_pkg.sv
// rtl/fc1_act_serializer_pkg.sv - shared FC1 geometry and quantisation defaults for the CNN core
package fc1_act_serializer_pkg;

    localparam int FC1_CO     = 3;
    localparam int FC1_ACC_BW = 24;
    localparam int FC1_B_BW   = 16;
    localparam int FC1_OUT_BW = 8;
    localparam int FC1_SHIFT  = 7;
    localparam int FC1_NGROUP = 16;

endpackage

// File: rtl/fc1_act_serializer_relu_quant.sv
// rtl/fc1_act_serializer_relu_quant.sv - one lane of bias add, ReLU and saturating requantisation
module fc_relu_quant
    import fc1_act_serializer_pkg::*;
#(
    parameter int ACC_BW = FC1_ACC_BW,
    parameter int B_BW   = FC1_B_BW,
    parameter int OUT_BW = FC1_OUT_BW,
    parameter int SHIFT  = FC1_SHIFT
) (
    input  logic [ACC_BW-1:0] i_acc,
    input  logic [B_BW-1:0]   i_bias,
    output logic [OUT_BW-1:0] o_act
);

    logic signed [ACC_BW:0] sum;
    logic        [ACC_BW:0] shifted;

    // One guard bit keeps acc + bias exact for any input pair.
    assign sum = $signed({i_acc[ACC_BW-1], i_acc})
               + $signed({{(ACC_BW + 1 - B_BW){i_bias[B_BW-1]}}, i_bias});

    always_comb begin
        shifted = sum >>> SHIFT;
        if (sum[ACC_BW]) begin
            o_act = '0;
        end else if (|shifted[ACC_BW:OUT_BW]) begin
            o_act = '1;
        end else begin
            o_act = shifted[OUT_BW-1:0];
        end
    end

endmodule

// File: rtl/fc1_act_serializer.sv
// rtl/fc1_act_serializer.sv - turns FC1 accumulator beats into a ready/valid stream of activations
module fc1_act_serializer
    import fc1_act_serializer_pkg::*;
#(
    parameter int CO     = FC1_CO,
    parameter int ACC_BW = FC1_ACC_BW,
    parameter int B_BW   = FC1_B_BW,
    parameter int OUT_BW = FC1_OUT_BW,
    parameter int SHIFT  = FC1_SHIFT,
    parameter int NGROUP = FC1_NGROUP,
    // Bias ROM image (contents of fc1_bias.mem), entry n at [n*B_BW +: B_BW].
    parameter logic [CO*NGROUP*B_BW-1:0] BIAS_INIT = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_in_valid,
    input  logic [CO*ACC_BW-1:0]          i_in_acc,
    output logic                          o_ot_valid,
    input  logic                          i_ot_ready,
    output logic [OUT_BW-1:0]             o_ot_data,
    output logic [$clog2(CO*NGROUP)-1:0]  o_ot_idx,
    output logic                          o_ot_last,
    output logic                          o_busy,
    output logic                          o_overrun
);

    localparam int NB    = CO * NGROUP;
    localparam int IDX_W = $clog2(NB);
    localparam int LW    = (CO > 1) ? $clog2(CO) : 1;
    localparam int GW    = (NGROUP > 1) ? $clog2(NGROUP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_SEND
    } state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      group_q, group_d;
    logic [LW-1:0]      lane_q, lane_d;
    logic [ACC_BW-1:0]  acc_q [CO];
    logic [ACC_BW-1:0]  acc_d [CO];
    logic [OUT_BW-1:0]  obuf_q [CO];
    logic [OUT_BW-1:0]  obuf_d [CO];
    logic               overrun_q, overrun_d;

    logic [B_BW-1:0]    bias_rom [NB];
    logic [OUT_BW-1:0]  act [CO];
    logic [IDX_W-1:0]   base_idx;

    assign base_idx = IDX_W'(group_q) * IDX_W'(CO);

    for (genvar b = 0; b < NB; b++) begin : g_rom
        assign bias_rom[b] = BIAS_INIT[b*B_BW +: B_BW];
    end

    for (genvar k = 0; k < CO; k++) begin : g_lane
        logic [IDX_W-1:0] bidx;
        assign bidx = base_idx + IDX_W'(k);

        fc_relu_quant #(
            .ACC_BW (ACC_BW),
            .B_BW   (B_BW),
            .OUT_BW (OUT_BW),
            .SHIFT  (SHIFT)
        ) u_relu_quant (
            .i_acc  (acc_q[k]),
            .i_bias (bias_rom[bidx]),
            .o_act  (act[k])
        );
    end

    always_comb begin
        state_d   = state_q;
        group_d   = group_q;
        lane_d    = lane_q;
        overrun_d = overrun_q;
        for (int k = 0; k < CO; k++) begin
            acc_d[k]  = acc_q[k];
            obuf_d[k] = obuf_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (i_in_valid) begin
                    for (int k = 0; k < CO; k++) begin
                        acc_d[k] = i_in_acc[k*ACC_BW +: ACC_BW];
                    end
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                for (int k = 0; k < CO; k++) begin
                    obuf_d[k] = act[k];
                end
                lane_d  = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (i_ot_ready) begin
                    if (lane_q == LW'(CO - 1)) begin
                        lane_d  = '0;
                        group_d = (group_q == GW'(NGROUP - 1)) ? '0 : group_q + 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A beat arriving outside IDLE, including on the final handshake, is lost.
        if (i_in_valid && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            group_q   <= '0;
            lane_q    <= '0;
            overrun_q <= 1'b0;
            for (int k = 0; k < CO; k++) begin
                acc_q[k]  <= '0;
                obuf_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            group_q   <= group_d;
            lane_q    <= lane_d;
            overrun_q <= overrun_d;
            for (int k = 0; k < CO; k++) begin
                acc_q[k]  <= acc_d[k];
                obuf_q[k] <= obuf_d[k];
            end
        end
    end

    assign o_ot_valid = (state_q == ST_SEND);
    assign o_ot_data  = o_ot_valid ? obuf_q[lane_q] : '0;
    assign o_ot_idx   = o_ot_valid ? base_idx + IDX_W'(lane_q) : '0;
    assign o_ot_last  = o_ot_valid && (group_q == GW'(NGROUP - 1)) && (lane_q == LW'(CO - 1));
    assign o_busy     = (state_q != ST_IDLE);
    assign o_overrun  = overrun_q;

endmodule
